// File: rtl/sipo.sv
// rtl/sipo.sv - serial-in/parallel-out receiver paired with the piso transmitter
module sipo #(
  parameter int WIDTH      = 42,
  parameter int EXTRA_BITS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + EXTRA_BITS + 2);
  localparam logic [CW-1:0] SKIP_LOAD  = CW'(EXTRA_BITS + 1);
  localparam logic [CW-1:0] SHIFT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done    = 1'b0;
    case (state_q)
      IDLE: ;
      SKIP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = SHIFT;
          cnt_d   = SHIFT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], data_in};
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A start always opens a fresh frame, even mid-frame or on the completion edge.
    if (start) begin
      state_d = SKIP;
      cnt_d   = SKIP_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid   <= done;
      busy    <= (state_d != IDLE);
      if (done) data_out <= shift_d;
    end
  end

endmodule

// File: tb/tb_sipo.sv
// tb/tb_sipo.sv - self-checking bench for sipo against a frame-timing reference model
module tb_sipo;

  localparam int W  = 42;
  localparam int E  = 9;
  localparam int C  = E + W + 1;
  localparam int W2 = 2;
  localparam int E2 = 0;
  localparam int C2 = E2 + W2 + 1;

  logic          clk = 1'b0;
  logic          rst, start, din, start2, din2;
  logic [W-1:0]  dout;
  logic          valid, busy;
  logic [W2-1:0] dout2;
  logic          valid2, busy2;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  last_word;
  logic [W2-1:0] last2;

  always #5 clk = ~clk;

  sipo #(.WIDTH(W), .EXTRA_BITS(E)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(din),
    .data_out(dout), .valid(valid), .busy(busy)
  );

  sipo #(.WIDTH(W2), .EXTRA_BITS(E2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(din2),
    .data_out(dout2), .valid(valid2), .busy(busy2)
  );

  // Transmitter model: bit on the line before edge E0+rel of a frame carrying w.
  function automatic logic bit_at(input logic [W-1:0] w, input int rel);
    if (rel <= E + 1) return 1'($urandom);
    return w[W-1-(rel-E-2)];
  endfunction

  function automatic logic bit_at2(input logic [W2-1:0] w, input int rel);
    if (rel <= E2 + 1) return 1'($urandom);
    return w[W2-1-(rel-E2-2)];
  endfunction

  task automatic step(input logic s, input logic d, input logic r, input logic s2, input logic d2);
    start = s; din = d; rst = r; start2 = s2; din2 = d2;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int vcnt, bcnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 1'b1, 1'b1, 1'($urandom));
      checks++;
      if (dout !== '0 || valid !== 1'b0 || busy !== 1'b0 ||
          dout2 !== '0 || valid2 !== 1'b0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got dout=%h valid=%b busy=%b dout2=%h valid2=%b busy2=%b exp all 0",
                 i, dout, valid, busy, dout2, valid2, busy2);
      end
    end
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'($urandom));
      vcnt += int'(valid) + int'(valid2);
      bcnt += int'(busy) + int'(busy2);
    end
    checks++;
    if (vcnt !== 0 || bcnt !== 0) begin
      errors++;
      $display("FAIL reset_release got valid_cycles=%0d busy_cycles=%0d exp 0 0", vcnt, bcnt);
    end
    last_word = '0;
    last2 = '0;
  endtask

  task automatic test_loopback(input logic [W-1:0] w);
    int bcnt;
    step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    bcnt = int'(busy);
    for (int n = 1; n <= C; n++) begin
      step(1'b0, bit_at(w, n), 1'b0, 1'b0, 1'b0);
      bcnt += int'(busy);
      checks++;
      if (valid !== (n == C)) begin
        errors++;
        $display("FAIL loop_valid n=%0d got %b exp %b", n, valid, (n == C));
      end
      checks++;
      if (dout !== ((n == C) ? w : last_word)) begin
        errors++;
        $display("FAIL loop_data n=%0d got %h exp %h", n, dout, (n == C) ? w : last_word);
      end
    end
    checks++;
    if (bcnt !== C) begin
      errors++;
      $display("FAIL loop_busy_len got %0d exp %0d", bcnt, C);
    end
    step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_after got valid=%b busy=%b exp 0 0", valid, busy);
    end
    last_word = w;
  endtask

  task automatic test_back_to_back(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp_d;
    step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 2 * C; n++) begin
      step(n == C, (n <= C) ? bit_at(a, n) : bit_at(b, n - C), 1'b0, 1'b0, 1'b0);
      exp_d = (n < C) ? last_word : (n < 2 * C) ? a : b;
      checks++;
      if (valid !== (n == C || n == 2 * C)) begin
        errors++;
        $display("FAIL b2b_valid n=%0d got %b exp %b", n, valid, (n == C || n == 2 * C));
      end
      checks++;
      if (dout !== exp_d) begin
        errors++;
        $display("FAIL b2b_data n=%0d got %h exp %h", n, dout, exp_d);
      end
      checks++;
      if (busy !== (n < 2 * C)) begin
        errors++;
        $display("FAIL b2b_busy n=%0d got %b exp %b", n, busy, (n < 2 * C));
      end
    end
    last_word = b;
  endtask

  task automatic test_restart(input logic [W-1:0] a, input logic [W-1:0] b);
    localparam int R = 30;
    step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= R + C; n++) begin
      step(n == R, (n < R) ? bit_at(a, n) : bit_at(b, n - R), 1'b0, 1'b0, 1'b0);
      checks++;
      if (valid !== (n == R + C)) begin
        errors++;
        $display("FAIL restart_valid n=%0d got %b exp %b", n, valid, (n == R + C));
      end
      checks++;
      if (dout !== ((n == R + C) ? b : last_word)) begin
        errors++;
        $display("FAIL restart_data n=%0d got %h exp %h", n, dout, (n == R + C) ? b : last_word);
      end
      checks++;
      if (busy !== (n < R + C)) begin
        errors++;
        $display("FAIL restart_busy n=%0d got %b exp %b", n, busy, (n < R + C));
      end
    end
    last_word = b;
  endtask

  task automatic test_reset_mid(input logic [W-1:0] w);
    int vcnt, bcnt;
    step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int n = 1; n < 40; n++) step(1'b0, bit_at(w, n), 1'b0, 1'b0, 1'b0);
    step(1'b0, bit_at(w, 40), 1'b1, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL rstmid_state got busy=%b valid=%b dout=%h exp 0 0 0", busy, valid, dout);
    end
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
      vcnt += int'(valid);
      bcnt += int'(busy) + int'(dout != '0);
    end
    checks++;
    if (vcnt !== 0 || bcnt !== 0) begin
      errors++;
      $display("FAIL rstmid_after got valid_cycles=%0d busy_or_data_cycles=%0d exp 0 0", vcnt, bcnt);
    end
    last_word = '0;
    last2 = '0;
  endtask

  task automatic test_small(input logic [W2-1:0] a, input logic [W2-1:0] b);
    logic [W2-1:0] exp_d;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom));
    for (int n = 1; n <= 2 * C2; n++) begin
      step(1'b0, 1'b0, 1'b0, n == C2, (n <= C2) ? bit_at2(a, n) : bit_at2(b, n - C2));
      exp_d = (n < C2) ? last2 : (n < 2 * C2) ? a : b;
      checks++;
      if (valid2 !== (n == C2 || n == 2 * C2)) begin
        errors++;
        $display("FAIL small_valid n=%0d got %b exp %b", n, valid2, (n == C2 || n == 2 * C2));
      end
      checks++;
      if (dout2 !== exp_d) begin
        errors++;
        $display("FAIL small_data n=%0d got %b exp %b", n, dout2, exp_d);
      end
      checks++;
      if (busy2 !== (n < 2 * C2)) begin
        errors++;
        $display("FAIL small_busy n=%0d got %b exp %b", n, busy2, (n < 2 * C2));
      end
    end
    last2 = b;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 1'b0; start2 = 1'b0; din2 = 1'b0;
    last_word = '0; last2 = '0;
    test_reset();
    test_loopback(42'h2AB_CDEF_0123);
    for (int i = 0; i < 4; i++) test_loopback(W'({$urandom, $urandom}));
    test_back_to_back(42'h3FF_FFFF_FFFF, 42'h000_0000_0001);
    test_back_to_back(W'({$urandom, $urandom}), W'({$urandom, $urandom}));
    test_restart(W'({$urandom, $urandom}), 42'h155_5555_5555);
    test_reset_mid(W'({$urandom, $urandom}) | 42'h1);
    test_small(2'b10, 2'b01);
    for (int i = 0; i < 4; i++) test_small(2'($urandom), 2'($urandom));
    test_loopback(W'({$urandom, $urandom}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
